// File: rtl/mux_n_rr_reg.sv
// rtl/mux_n_rr_reg.sv - N-channel valid/ready mux with direct or round-robin select into a registered output
// Optional build macro: MUX_CHAN_TAG_EN (Out_Chan reports the source channel of Out_Data).
module mux_n_rr_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        Sel,
    input  logic [NUM_IN*WIDTH-1:0] In_Data,
    input  logic [NUM_IN-1:0]       In_Valid,
    output logic [NUM_IN-1:0]       In_Ready,
    output logic [WIDTH-1:0]        Out_Data,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [SEL_W-1:0]        Out_Chan
);

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             free;
    logic             transfer;

    assign free     = !Out_Valid || Out_Ready;
    assign transfer = grant_ok && free && sel_valid && Rst_n;

    // Round-robin search starts one past the last granted channel and wraps.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_ok = 1'b0;
        if (!Mode) begin
            grant    = Sel;
            grant_ok = (int'(Sel) < NUM_IN);
        end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                idx = (int'(last) + k) % NUM_IN;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!grant_ok && (i == idx) && In_Valid[i]) begin
                        grant    = SEL_W'(i);
                        grant_ok = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        In_Ready  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_ok && (grant == SEL_W'(i))) begin
                sel_valid   = In_Valid[i];
                sel_data    = In_Data[i*WIDTH +: WIDTH];
                In_Ready[i] = free && Rst_n;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            last      <= SEL_W'(NUM_IN - 1);
        end else if (transfer) begin
            Out_Valid <= 1'b1;
            Out_Data  <= sel_data;
            if (Mode) begin
                last <= grant;
            end
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

`ifdef MUX_CHAN_TAG_EN
    logic [SEL_W-1:0] chan_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            chan_q <= '0;
        end else if (transfer) begin
            chan_q <= grant;
        end
    end

    assign Out_Chan = chan_q;
`else
    assign Out_Chan = '0;
`endif

endmodule
